mem_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX/MEM register. It consumes that register's ALU result, store data, rd, PC+4 and control fields.
- Drives a req/ack data-memory port that accepts variable latency. Generates byte strobes for stores and aligns/extends load data.
- Stalls the upstream pipeline while an access is outstanding.
- Ends in the MEM/WB pipeline register, whose outputs feed the writeback mux.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_load_align.sv | 39 +++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: access sizes, FSM states, writeback selects.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects byte/halfword from the read word and extends.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr)
            2'b00: byte_sel = rdata[7:0];
            2'b01: byte_sel = rdata[15:8];
            2'b10: byte_sel = rdata[23:16];
            2'b11: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // halfword lane chosen by addr[1] only; addr[0] is ignored
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (size)
            MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  data = {24'h0, byte_sel};
            MEM_H:   data = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data port, store lanes, load align, MEM/WB reg.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] alu_res_in,
    input  logic [DATA_WIDTH-1:0] w_data_in,
    input  logic [REG_WIDTH-1:0]  rd_in,
    input  logic [PC_WIDTH-1:0]   pc_plus4_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            result_src_in,
    input  logic                  mem_write_in,
    input  logic                  mem_read_in,
    input  logic [2:0]            mem_size_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall_out,
    output logic [DATA_WIDTH-1:0] alu_res_out,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic [REG_WIDTH-1:0]  rd_out,
    output logic [PC_WIDTH-1:0]   pc_plus4_out,
    output logic                  reg_write_out,
    output logic [1:0]            result_src_out,
    output logic                  misalign_exc
);

    mem_state_e state, state_nxt;

    logic access;
    logic is_load;
    logic mis;
    logic req_int;
    logic size_b;
    logic size_h;
    logic size_w;
    logic [1:0] off;
    logic [DATA_WIDTH-1:0] ld_data;

    assign access  = mem_read_in | mem_write_in;
    assign is_load = mem_read_in & ~mem_write_in;
    assign off     = alu_res_in[1:0];
    assign size_b  = (mem_size_in[1:0] == 2'b00);
    assign size_h  = (mem_size_in[1:0] == 2'b01);
    assign size_w  = mem_size_in[1];

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        mis = 1'b0;
        unique case (1'b1)
            size_h:  mis = off[0];
            size_w:  mis = |off;
            default: mis = 1'b0;
        endcase
        mis = mis & access;
    end
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_int   = 1'b0;
        case (state)
            IDLE: begin
                req_int = access & ~mis;
                if (req_int && !dmem_ack) state_nxt = WAIT;
            end
            WAIT: begin
                req_int = 1'b1;
                if (dmem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // gate with reset so the request drops the instant reset asserts
    assign dmem_req  = rst & req_int;
    assign stall_out = dmem_req & ~dmem_ack;

    assign dmem_we   = mem_write_in;
    assign dmem_addr = {alu_res_in[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = w_data_in;
        if (mem_write_in) begin
            unique case (1'b1)
                size_b: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{w_data_in[7:0]}};
                end
                size_h: begin
                    dmem_be    = 4'b0011 << {off[1], 1'b0};
                    dmem_wdata = {2{w_data_in[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = w_data_in;
                end
            endcase
        end
    end

    mem_load_align u_align (
        .rdata (dmem_rdata),
        .addr  (off),
        .size  (mem_size_in),
        .data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_res_out    <= '0;
            read_data_out  <= '0;
            rd_out         <= '0;
            pc_plus4_out   <= '0;
            reg_write_out  <= 1'b0;
            result_src_out <= '0;
        end else if (stall_out) begin
            reg_write_out  <= 1'b0;
        end else begin
            alu_res_out    <= alu_res_in;
            read_data_out  <= (is_load & ~mis) ? ld_data : '0;
            rd_out         <= rd_in;
            pc_plus4_out   <= pc_plus4_in;
            reg_write_out  <= reg_write_in & ~mis;
            result_src_out <= result_src_in;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= mis & ~stall_out;
        end
    end
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expectations.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res_in;
    logic [31:0] w_data_in;
    logic [4:0]  rd_in;
    logic [31:0] pc_plus4_in;
    logic        reg_write_in;
    logic [1:0]  result_src_in;
    logic        mem_write_in;
    logic        mem_read_in;
    logic [2:0]  mem_size_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out;
    logic [31:0] alu_res_out;
    logic [31:0] read_data_out;
    logic [4:0]  rd_out;
    logic [31:0] pc_plus4_out;
    logic        reg_write_out;
    logic [1:0]  result_src_out;
    logic        misalign_exc;

    int checks;
    int failures;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .alu_res_in     (alu_res_in),
        .w_data_in      (w_data_in),
        .rd_in          (rd_in),
        .pc_plus4_in    (pc_plus4_in),
        .reg_write_in   (reg_write_in),
        .result_src_in  (result_src_in),
        .mem_write_in   (mem_write_in),
        .mem_read_in    (mem_read_in),
        .mem_size_in    (mem_size_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .stall_out      (stall_out),
        .alu_res_out    (alu_res_out),
        .read_data_out  (read_data_out),
        .rd_out         (rd_out),
        .pc_plus4_out   (pc_plus4_out),
        .reg_write_out  (reg_write_out),
        .result_src_out (result_src_out),
        .misalign_exc   (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // rd, wr, size, addr, wdata, rd index, reg_write, result_src
    task automatic op(input logic rd, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rdi, input logic rw,
                      input logic [1:0] rs);
        mem_read_in   = rd;
        mem_write_in  = wr;
        mem_size_in   = sz;
        alu_res_in    = a;
        w_data_in     = wd;
        rd_in         = rdi;
        reg_write_in  = rw;
        result_src_in = rs;
        pc_plus4_in   = a + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 1'b1, 2'b01);
        #12;
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_out}, 32'h0);
        chk("rst_alu", alu_res_out, 32'h0);
        chk("rst_rdata", read_data_out, 32'h0);
        chk("rst_rw", {31'h0, reg_write_out}, 32'h0);
        chk("rst_pc", pc_plus4_out, 32'h0);
        op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        step();

        // zero-wait LW
        op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 2'b01);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_req", {31'h0, dmem_req}, 32'h1);
        chk("lw_stall", {31'h0, stall_out}, 32'h0);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_be", {28'h0, dmem_be}, 32'hF);
        chk("lw_we", {31'h0, dmem_we}, 32'h0);
        step();
        chk("lw_data", read_data_out, 32'hDEADBEEF);
        chk("lw_rw", {31'h0, reg_write_out}, 32'h1);
        chk("lw_rd", {27'h0, rd_out}, 32'd5);
        chk("lw_src", {30'h0, result_src_out}, 32'h1);
        chk("lw_pc", pc_plus4_out, 32'h104);

        // SB at 0x203
        op(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd0, 1'b0, 2'b00);
        #1;
        chk("sb_be", {28'h0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", dmem_addr, 32'h200);
        chk("sb_we", {31'h0, dmem_we}, 32'h1);
        step();
        chk("sb_rdata0", read_data_out, 32'h0);
        chk("sb_rw", {31'h0, reg_write_out}, 32'h0);

        // SH at 0x102, SW at 0x300
        op(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 1'b0, 2'b00);
        #1;
        chk("sh_be", {28'h0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        step();
        op(1'b0, 1'b1, 3'b010, 32'h300, 32'h1234ABCD, 5'd0, 1'b0, 2'b00);
        #1;
        chk("sw_be", {28'h0, dmem_be}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'h1234ABCD);
        step();

        // byte/half loads from 0x80FF7F01
        dmem_rdata = 32'h80FF7F01;
        op(1'b1, 1'b0, 3'b000, 32'h402, 32'h0, 5'd6, 1'b1, 2'b01);
        #1;
        chk("lb_be", {28'h0, dmem_be}, 32'hF);
        step();
        chk("lb_off2", read_data_out, 32'hFFFFFFFF);
        op(1'b1, 1'b0, 3'b100, 32'h402, 32'h0, 5'd6, 1'b1, 2'b01);
        step();
        chk("lbu_off2", read_data_out, 32'h000000FF);
        op(1'b1, 1'b0, 3'b001, 32'h402, 32'h0, 5'd6, 1'b1, 2'b01);
        step();
        chk("lh_off2", read_data_out, 32'hFFFF80FF);
        op(1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 5'd6, 1'b1, 2'b01);
        step();
        chk("lhu_off2", read_data_out, 32'h000080FF);
        op(1'b1, 1'b0, 3'b000, 32'h403, 32'h0, 5'd6, 1'b1, 2'b01);
        step();
        chk("lb_off3", read_data_out, 32'hFFFFFF80);
        op(1'b1, 1'b0, 3'b000, 32'h401, 32'h0, 5'd6, 1'b1, 2'b01);
        step();
        chk("lb_off1", read_data_out, 32'h0000007F);
        op(1'b1, 1'b0, 3'b101, 32'h400, 32'h0, 5'd6, 1'b1, 2'b01);
        step();
        chk("lhu_off0", read_data_out, 32'h00007F01);

        // non-memory ALU op
        dmem_ack = 1'b0;
        op(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9, 1'b1, 2'b00);
        #1;
        chk("alu_req", {31'h0, dmem_req}, 32'h0);
        chk("alu_stall", {31'h0, stall_out}, 32'h0);
        step();
        chk("alu_res", alu_res_out, 32'h55);
        chk("alu_rdata0", read_data_out, 32'h0);
        chk("alu_rw", {31'h0, reg_write_out}, 32'h1);
        chk("alu_rd", {27'h0, rd_out}, 32'd9);

        // 3-cycle latency load
        op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd7, 1'b1, 2'b01);
        dmem_rdata = 32'hAAAAAAAA;
        #1;
        chk("lat_stall1", {31'h0, stall_out}, 32'h1);
        step();
        chk("lat_bub1_rw", {31'h0, reg_write_out}, 32'h0);
        chk("lat_bub1_alu", alu_res_out, 32'h55);
        chk("lat_req2", {31'h0, dmem_req}, 32'h1);
        chk("lat_stall2", {31'h0, stall_out}, 32'h1);
        step();
        chk("lat_bub2_rw", {31'h0, reg_write_out}, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h11223344;
        #1;
        chk("lat_stall3", {31'h0, stall_out}, 32'h0);
        chk("lat_req3", {31'h0, dmem_req}, 32'h1);
        step();
        chk("lat_data", read_data_out, 32'h11223344);
        chk("lat_rw", {31'h0, reg_write_out}, 32'h1);
        chk("lat_alu", alu_res_out, 32'h500);

        // back-to-back load straight after the ack
        op(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 5'd8, 1'b1, 2'b01);
        dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("b2b_stall", {31'h0, stall_out}, 32'h0);
        step();
        chk("b2b_data", read_data_out, 32'hCAFEF00D);

        // reset during WAIT
        dmem_ack = 1'b0;
        op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd3, 1'b1, 2'b01);
        step();
        chk("rw_wait_stall", {31'h0, stall_out}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rw_req", {31'h0, dmem_req}, 32'h0);
        chk("rw_stall", {31'h0, stall_out}, 32'h0);
        chk("rw_alu", alu_res_out, 32'h0);
        op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        dmem_ack = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        dmem_ack = 1'b0;
        #1;
        chk("rw_idle_req", {31'h0, dmem_req}, 32'h0);
        chk("rw_idle_stall", {31'h0, stall_out}, 32'h0);
        chk("rw_out_rdata", read_data_out, 32'h0);
        chk("rw_out_rw", {31'h0, reg_write_out}, 32'h0);
        chk("rw_out_rd", {27'h0, rd_out}, 32'h0);

        // misaligned LW at 0x102
        dmem_ack = 1'b0;
        op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd4, 1'b1, 2'b01);
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", {31'h0, dmem_req}, 32'h0);
        chk("mis_stall", {31'h0, stall_out}, 32'h0);
        step();
        chk("mis_exc", {31'h0, misalign_exc}, 32'h1);
        chk("mis_rw", {31'h0, reg_write_out}, 32'h0);
        op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        step();
        chk("mis_exc_clr", {31'h0, misalign_exc}, 32'h0);
`else
        chk("mis_req", {31'h0, dmem_req}, 32'h1);
        chk("mis_addr", dmem_addr, 32'h100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        step();
        chk("mis_exc", {31'h0, misalign_exc}, 32'h0);
        chk("mis_data", read_data_out, 32'h0BADF00D);
        chk("mis_rw", {31'h0, reg_write_out}, 32'h1);
        dmem_ack = 1'b0;
        op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
